// File: rtl/toy_pack.sv
// Shared types for the MSHR dependency scheduler.
// Entry lifecycle states and small helpers.
package toy_pack;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DEP,
    ST_ISSUE,
    ST_WAIT_FILL,
    ST_HIT_WAIT,
    ST_DONE
  } mshr_dep_state_t;

  // State an entry takes once nothing older blocks it.
  function automatic mshr_dep_state_t ready_st(input logic miss);
    return miss ? ST_ISSUE : ST_HIT_WAIT;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: first set request at or after ptr.
// Reports index 0 when nothing is requesting.
module rr_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         vld,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] j;

  always_comb begin
    vld   = |req;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/mshr_dep_sched.sv
// MSHR entry scheduler: dependency tracking, linefill issue
// and release arbitration across all entries.
module mshr_dep_sched
  import toy_pack::*;
#(
  parameter int MSHR_ENTRY_NUM         = 8,
  parameter int MSHR_ENTRY_INDEX_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_vld,
  input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] alloc_index,
  input  logic [MSHR_ENTRY_NUM-1:0]         alloc_bitmap,
  input  logic                              alloc_is_miss,
  output logic                              dn_req_vld,
  input  logic                              dn_req_rdy,
  output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] dn_req_index,
  input  logic                              linefill_done_vld,
  input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_done_index,
  input  logic [MSHR_ENTRY_NUM-1:0]         v_hit_entry_done,
  output logic                              release_vld,
  output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] release_index,
  output logic [MSHR_ENTRY_NUM-1:0]         v_entry_busy,
  output logic                              err
);

  localparam int N = MSHR_ENTRY_NUM;
  localparam int W = MSHR_ENTRY_INDEX_WIDTH;

  mshr_dep_state_t state_q [N];
  mshr_dep_state_t state_d [N];
  logic [N-1:0]    bm_q [N];
  logic [N-1:0]    bm_d [N];
  logic [N-1:0]    miss_q, miss_d;
  logic [W-1:0]    iss_ptr_q, rel_ptr_q, lock_idx_q;
  logic            lock_q, err_q;

  logic [N-1:0] idle_mask, issue_mask, fill_mask;
  logic [N-1:0] hitw_mask, done_mask;
  logic [N-1:0] rel_oh, alloc_oh, lf_oh, iss_oh, alloc_bm;
  logic [W-1:0] iss_idx;
  logic         hs, alloc_ok, err_set;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] i);
    return (int'(i) >= N - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    idle_mask  = '0;
    issue_mask = '0;
    fill_mask  = '0;
    hitw_mask  = '0;
    done_mask  = '0;
    for (int i = 0; i < N; i++) begin
      idle_mask[i]  = state_q[i] == ST_IDLE;
      issue_mask[i] = state_q[i] == ST_ISSUE;
      fill_mask[i]  = state_q[i] == ST_WAIT_FILL;
      hitw_mask[i]  = state_q[i] == ST_HIT_WAIT;
      done_mask[i]  = state_q[i] == ST_DONE;
    end
  end

  rr_arb #(.N(N), .W(W)) u_iss_arb (
    .req (issue_mask),
    .ptr (iss_ptr_q),
    .vld (dn_req_vld),
    .idx (iss_idx)
  );

  rr_arb #(.N(N), .W(W)) u_rel_arb (
    .req (done_mask),
    .ptr (rel_ptr_q),
    .vld (release_vld),
    .idx (release_index)
  );

  // A stalled grant stays put; its entry cannot leave ISSUE.
  assign dn_req_index = lock_q ? lock_idx_q : iss_idx;
  assign hs           = dn_req_vld & dn_req_rdy;
  assign v_entry_busy = ~idle_mask;
  assign err          = err_q;

  assign alloc_ok = alloc_vld & idle_mask[alloc_index];
  assign rel_oh   = release_vld ? N'(1) << release_index : '0;
  assign alloc_oh = alloc_ok ? N'(1) << alloc_index : '0;
  assign lf_oh    = linefill_done_vld ?
                    N'(1) << linefill_done_index : '0;
  assign iss_oh   = hs ? N'(1) << dn_req_index : '0;
  assign alloc_bm = alloc_bitmap & ~rel_oh
                  & ~(N'(1) << alloc_index);

  assign err_set = (alloc_vld & ~idle_mask[alloc_index])
    | (linefill_done_vld & ~fill_mask[linefill_done_index])
    | (|(v_hit_entry_done & ~hitw_mask));

  always_comb begin
    miss_d = miss_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      bm_d[i]    = bm_q[i] & ~rel_oh;
      case (state_q[i])
        ST_IDLE:
          if (alloc_oh[i]) begin
            bm_d[i]    = alloc_bm;
            miss_d[i]  = alloc_is_miss;
            state_d[i] = (alloc_bm == '0) ?
                         ready_st(alloc_is_miss) : ST_WAIT_DEP;
          end
        ST_WAIT_DEP:
          if (bm_d[i] == '0) state_d[i] = ready_st(miss_q[i]);
        ST_ISSUE:
          if (iss_oh[i]) state_d[i] = ST_WAIT_FILL;
        ST_WAIT_FILL:
          if (lf_oh[i]) state_d[i] = ST_DONE;
        ST_HIT_WAIT:
          if (v_hit_entry_done[i]) state_d[i] = ST_DONE;
        ST_DONE:
          if (rel_oh[i]) state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        bm_q[i]    <= '0;
      end
      miss_q     <= '0;
      iss_ptr_q  <= '0;
      rel_ptr_q  <= '0;
      lock_idx_q <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        bm_q[i]    <= bm_d[i];
      end
      miss_q     <= miss_d;
      lock_q     <= dn_req_vld & ~dn_req_rdy;
      lock_idx_q <= dn_req_index;
      err_q      <= err_q | err_set;
      if (hs) iss_ptr_q <= nxt(dn_req_index);
      if (release_vld) rel_ptr_q <= nxt(release_index);
    end
  end

endmodule

// File: doc/mshr_dep_sched.md
MSHR_DEP_SCHED -- requirements
Module: mshr_dep_sched

Interface
REQ-001 SHALL have parameter MSHR_ENTRY_NUM, default 8, number of MSHR entries tracked.
REQ-002 SHALL have parameter MSHR_ENTRY_INDEX_WIDTH, default 3, entry index width, equal to clog2(MSHR_ENTRY_NUM).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_vld  input  1  entry allocation this cycle.
REQ-006 SHALL have port alloc_index  input  MSHR_ENTRY_INDEX_WIDTH  entry being allocated.
REQ-007 SHALL have port alloc_bitmap  input  MSHR_ENTRY_NUM  same-index/same-way older entries the new entry waits on (row alloc_index of the hazard-check bitmap).
REQ-008 SHALL have port alloc_is_miss  input  1  1 = miss entry needing linefill, 0 = hit entry.
REQ-009 SHALL have port dn_req_vld  output  1  downstream linefill request valid.
REQ-010 SHALL have port dn_req_rdy  input  1  downstream accepts request.
REQ-011 SHALL have port dn_req_index  output  MSHR_ENTRY_INDEX_WIDTH  entry issuing the request.
REQ-012 SHALL have port linefill_done_vld  input  1  linefill for an entry completed.
REQ-013 SHALL have port linefill_done_index  input  MSHR_ENTRY_INDEX_WIDTH  entry whose linefill completed.
REQ-014 SHALL have port v_hit_entry_done  input  MSHR_ENTRY_NUM  per-entry hit-service completion pulse.
REQ-015 SHALL have port release_vld  output  1  one entry freed this cycle.
REQ-016 SHALL have port release_index  output  MSHR_ENTRY_INDEX_WIDTH  freed entry.
REQ-017 SHALL have port v_entry_busy  output  MSHR_ENTRY_NUM  entry state not IDLE.
REQ-018 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL keep per entry a state in {IDLE, WAIT_DEP, ISSUE, WAIT_FILL, HIT_WAIT, DONE} and a MSHR_ENTRY_NUM-bit dependency bitmap.
REQ-020 SHALL define rel_onehot = one-hot of release_index when release_vld, else 0; effective bitmap = stored bitmap & ~rel_onehot.
REQ-021 SHALL on alloc to an IDLE entry store alloc_bitmap & ~rel_onehot with own bit forced 0; next state: miss -> ISSUE if stored value zero else WAIT_DEP; hit -> HIT_WAIT if zero else WAIT_DEP.
REQ-022 SHALL move WAIT_DEP -> ISSUE (miss) or HIT_WAIT (hit) on the cycle the effective bitmap is zero; a release at cycle t unblocks a dependant into its next state at t+1.
REQ-023 SHALL clear bit j of every stored bitmap at the edge ending a cycle with release of entry j.
REQ-024 SHALL select among ISSUE entries by round-robin (pointer to entry after last accepted); dn_req_vld = any ISSUE entry.
REQ-025 SHALL hold dn_req_index stable while dn_req_vld && !dn_req_rdy; grant locked until handshake.
REQ-026 SHALL on dn_req_vld && dn_req_rdy move granted entry ISSUE -> WAIT_FILL and advance pointer.
REQ-027 SHALL on linefill_done_vld move entry linefill_done_index WAIT_FILL -> DONE; in any other state ignore and set err.
REQ-028 SHALL on v_hit_entry_done[i] move entry i HIT_WAIT -> DONE; in any other state ignore and set err.
REQ-029 SHALL release at most one DONE entry per cycle, round-robin pointer independent of issue; release_vld/release_index combinational from registered state; released entry -> IDLE next edge.
REQ-030 SHALL set err on alloc_vld to a non-IDLE entry, leaving that entry unchanged.
REQ-031 SHALL accept alloc of entry j in the cycle after j is released; alloc to j in the same cycle as its release sets err.
REQ-032 SHALL give latency: alloc miss with zero bitmap at t -> dn_req_vld at t+1; linefill_done at t -> release_vld at t+1 when uncontended.

Reset
REQ-033 SHALL on rst asynchronously set all states IDLE, bitmaps 0, both pointers 0, err 0; hence dn_req_vld 0, dn_req_index 0, release_vld 0, release_index 0, v_entry_busy 0.
REQ-034 SHALL abandon in-flight requests on reset mid-operation; no release pulses generated for them.

Structure
REQ-035 SHALL place the entry-state enum (mshr_dep_state_t) in toy_pack.
REQ-036 SHALL instantiate a parameterised round-robin arbiter sub-module rr_arb twice (issue, release).

Verification
REQ-037 SHALL cover: alloc miss idx2 bitmap 0 at t, dn_req_rdy=1 -> dn_req_vld/idx2 at t+1, WAIT_FILL; linefill_done idx2 at t+5 -> release_vld/idx2 at t+6.
REQ-038 SHALL cover: idx1 in WAIT_FILL, alloc miss idx4 bitmap 8'h02 -> idx4 no request until idx1 released at t; dn_req idx4 at t+1.
REQ-039 SHALL cover: entries 0,3,5 in ISSUE, dn_req_rdy low 4 cycles -> index stays 0; then rdy high -> order 0,3,5.
REQ-040 SHALL cover: alloc idx6 bitmap 8'h01 in same cycle entry 0 released -> idx6 stored bitmap 0, dn_req_vld idx6 next cycle.
REQ-041 SHALL cover: linefill_done idx7 while idx7 IDLE -> err=1, no state change; rst mid-traffic -> all outputs 0 next cycle.
